alu_arbiter: RTL and testbench

//  Shares the single 8-bit ALU between two requesters: port 0 (core datapath) and port 1 (debug/DMA).

---
 rtl/alu_arbiter.sv | 111 +++++++++++
 tb/tb_alu_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two valid/ready ports; optional key latch via ALU_KEY_LATCH_EN
module alu_arbiter #(
  parameter int          ALU_LAT     = 1,
  parameter bit          RR_INIT     = 1'b0,
  parameter logic [7:0]  DEFAULT_KEY = 8'hD2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [3:0] req0_op,
  output logic       rsp0_valid,
  input  logic       rsp0_ready,
  output logic [7:0] rsp0_y,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic [3:0] req1_op,
  output logic       rsp1_valid,
  input  logic       rsp1_ready,
  output logic [7:0] rsp1_y,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_opcode,
  output logic [7:0] alu_key,
  input  logic [7:0] alu_y,
  input  logic       key_we,
  input  logic [7:0] key_din,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t     state, nxt;
  logic       prio, gid, gnt_v, gnt_id, accept, rsp_hs;
  logic [7:0] a_q, b_q, y_q;
  logic [3:0] op_q;
  logic [1:0] lat_cnt;
  if (ALU_LAT < 1 || ALU_LAT > 4) begin : g_lat_chk
    $error("alu_arbiter: ALU_LAT must be within 1..4");
  end
  assign gnt_v  = req0_valid | req1_valid;
  assign gnt_id = (req0_valid & req1_valid) ? prio : req1_valid;
  assign accept = (state == IDLE) & gnt_v;
  assign rsp_hs = (state == RESP) & (gid ? rsp1_ready : rsp0_ready);
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : nxt;
  // next-state: IDLE -> EXEC on accept, EXEC -> RESP when latency expires, RESP -> IDLE on handshake
  always_comb
    nxt = (state == IDLE) ? (gnt_v ? EXEC : IDLE) :
          (state == EXEC) ? ((lat_cnt == 2'd0) ? RESP : EXEC) :
          (state == RESP) ? (rsp_hs ? IDLE : RESP) : IDLE;
  // operand/result/priority registers; operands hold their last value outside EXEC
  always_ff @(posedge clk)
    if (rst) begin
      prio    <= RR_INIT;
      gid     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      y_q     <= '0;
      lat_cnt <= '0;
    end else begin
      if (accept) begin
        a_q     <= gnt_id ? req1_a : req0_a;
        b_q     <= gnt_id ? req1_b : req0_b;
        op_q    <= gnt_id ? req1_op : req0_op;
        gid     <= gnt_id;
        lat_cnt <= 2'(ALU_LAT - 1);
      end else if (state == EXEC && lat_cnt != 2'd0)
        lat_cnt <= lat_cnt - 2'd1;
      if (state == EXEC && lat_cnt == 2'd0)
        y_q <= alu_y;
      if (rsp_hs)
        prio <= ~gid;
    end
  // handshake and status outputs decoded from state and grant
  always_comb begin
    req0_ready = accept & ~gnt_id;
    req1_ready = accept & gnt_id;
    rsp0_valid = (state == RESP) & ~gid;
    rsp1_valid = (state == RESP) & gid;
    busy       = state != IDLE;
  end
  assign rsp0_y     = y_q;
  assign rsp1_y     = y_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_opcode = op_q;
`ifdef ALU_KEY_LATCH_EN
  logic [7:0] key_reg, key_sh;
  // key_reg follows writes; the shadow snapshots it at accept so a same-cycle write misses the op
  always_ff @(posedge clk)
    if (rst) begin
      key_reg <= DEFAULT_KEY;
      key_sh  <= DEFAULT_KEY;
    end else begin
      if (key_we)
        key_reg <= key_din;
      if (accept)
        key_sh <= key_reg;
    end
  assign alu_key = key_sh;
`else
  logic unused_key;
  assign unused_key = ^{key_we, key_din};
  assign alu_key    = DEFAULT_KEY;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of arbitration, latency, stall, reset and key handling
module tb_alu_arbiter;
  logic       clk = 1'b0, rst = 1'b1;
  logic       req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0, key_we = 0;
  logic [7:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0, key_din = 0;
  logic [3:0] req0_op = 0, req1_op = 0;
  logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
  logic [7:0] rsp0_y, rsp1_y, alu_a, alu_b, alu_key, alu_y;
  logic [3:0] alu_opcode;
  logic       q_req0_ready, q_req1_ready, q_rsp0_valid, q_rsp1_valid, q_busy;
  logic [7:0] q_rsp0_y, q_rsp1_y, q_alu_a, q_alu_b, q_alu_key, q_alu_y;
  logic [3:0] q_alu_opcode;
  int pass_cnt = 0, tot = 0;
  always #5 clk = ~clk;
  function automatic logic [7:0] alu_f(input logic [7:0] a, b, input logic [3:0] op, input logic [7:0] k);
    if (op == 4'b1111) return a & b;
    if (op == 4'b0110) return ~a;
    if (op == 4'b1101) return (k == 8'hD2) ? a - b : a + b;
    return a + b;
  endfunction
  assign alu_y   = alu_f(alu_a, alu_b, alu_opcode, alu_key);
  assign q_alu_y = alu_f(q_alu_a, q_alu_b, q_alu_opcode, q_alu_key);
  alu_arbiter #(.ALU_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_y(rsp0_y),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_y(rsp1_y),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_key(alu_key), .alu_y(alu_y),
    .key_we(key_we), .key_din(key_din), .busy(busy));
  alu_arbiter #(.ALU_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(q_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .rsp0_valid(q_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_y(q_rsp0_y),
    .req1_valid(req1_valid), .req1_ready(q_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp1_valid(q_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_y(q_rsp1_y),
    .alu_a(q_alu_a), .alu_b(q_alu_b), .alu_opcode(q_alu_opcode), .alu_key(q_alu_key), .alu_y(q_alu_y),
    .key_we(key_we), .key_din(key_din), .busy(q_busy));
  task automatic cyc;
    @(posedge clk);
    #2;
  endtask
  task automatic do_reset;
    {req0_valid, req1_valid, rsp0_ready, rsp1_ready, key_we} = '0;
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask
  task automatic test_reset;
    do_reset();
    #1;
    tot++; if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy} !== 5'b0) $display("FAIL reset_ctl: got %b exp 00000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy}); else pass_cnt++;
    tot++; if ({rsp0_y, rsp1_y, alu_a, alu_b, alu_opcode} !== 36'h0) $display("FAIL reset_data: got %h exp 0", {rsp0_y, rsp1_y, alu_a, alu_b, alu_opcode}); else pass_cnt++;
    tot++; if (alu_key !== 8'hD2) $display("FAIL reset_key: got %h exp d2", alu_key); else pass_cnt++;
  endtask
  task automatic test_single;
    do_reset();
    req0_valid = 1; req0_a = 8'hF0; req0_b = 8'h3C; req0_op = 4'b1111; rsp0_ready = 1;
    #1;
    tot++; if (req0_ready !== 1'b1) $display("FAIL single_ready: got %b exp 1", req0_ready); else pass_cnt++;
    cyc();
    req0_valid = 0;
    #1;
    tot++; if ({busy, rsp0_valid, alu_a} !== {2'b10, 8'hF0}) $display("FAIL single_exec: got %h exp 2f0", {busy, rsp0_valid, alu_a}); else pass_cnt++;
    cyc();
    #1;
    tot++; if ({rsp0_valid, rsp0_y} !== {1'b1, 8'h30}) $display("FAIL single_rsp: got %h exp 130", {rsp0_valid, rsp0_y}); else pass_cnt++;
    cyc();
    #1;
    tot++; if ({busy, rsp0_valid} !== 2'b00) $display("FAIL single_done: got %b exp 00", {busy, rsp0_valid}); else pass_cnt++;
  endtask
  task automatic test_round_robin;
    int g[4];
    int n = 0;
    bit seen1 = 0;
    do_reset();
    req0_valid = 1; req0_a = 8'h01; req0_b = 8'h02; req0_op = 4'b0000;
    req1_valid = 1; req1_a = 8'h10; req1_b = 8'h20; req1_op = 4'b0000;
    rsp0_ready = 1; rsp1_ready = 1;
    #1;
    tot++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL rr_first: got %b exp 10", {req0_ready, req1_ready}); else pass_cnt++;
    for (int c = 0; c < 40 && n < 4; c++) begin
      if (req0_ready) g[n++] = 0;
      else if (req1_ready) g[n++] = 1;
      if (rsp1_valid && !seen1) begin
        seen1 = 1;
        tot++; if (rsp1_y !== 8'h30) $display("FAIL rr_y1: got %h exp 30", rsp1_y); else pass_cnt++;
      end
      cyc();
      #1;
    end
    tot++; if (n !== 4) $display("FAIL rr_timeout: got %0d grants exp 4", n); else pass_cnt++;
    for (int i = 0; i < n; i++) begin
      tot++; if (g[i] !== i % 2) $display("FAIL rr_grant%0d: got %0d exp %0d", i, g[i], i % 2); else pass_cnt++;
    end
    req0_valid = 0; req1_valid = 0;
  endtask
  task automatic test_stall;
    do_reset();
    req0_valid = 1; req0_a = 8'hAA; req0_b = 8'h0F; req0_op = 4'b1111; rsp0_ready = 0;
    req1_valid = 1; req1_a = 8'h01; req1_b = 8'h01; req1_op = 4'b0000; rsp1_ready = 1;
    #1;
    tot++; if (req0_ready !== 1'b1) $display("FAIL stall_accept: got %b exp 1", req0_ready); else pass_cnt++;
    cyc();
    req0_valid = 0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      #1;
      tot++; if ({rsp0_valid, rsp0_y, req1_ready, busy} !== {1'b1, 8'h0A, 2'b01}) $display("FAIL stall_hold%0d: got %h exp 429", i, {rsp0_valid, rsp0_y, req1_ready, busy}); else pass_cnt++;
      cyc();
    end
    rsp0_ready = 1;
    #1;
    tot++; if (rsp0_valid !== 1'b1) $display("FAIL stall_release: got %b exp 1", rsp0_valid); else pass_cnt++;
    cyc();
    #1;
    tot++; if ({rsp0_valid, req1_ready} !== 2'b01) $display("FAIL stall_next: got %b exp 01", {rsp0_valid, req1_ready}); else pass_cnt++;
    req1_valid = 0;
  endtask
  task automatic test_lat3;
    do_reset();
    req0_valid = 1; req0_a = 8'h5A; req0_b = 8'h00; req0_op = 4'b0110; rsp0_ready = 1;
    #1;
    tot++; if (q_req0_ready !== 1'b1) $display("FAIL lat3_accept: got %b exp 1", q_req0_ready); else pass_cnt++;
    cyc();
    req0_valid = 0;
    for (int i = 1; i <= 3; i++) begin
      #1;
      tot++; if ({q_busy, q_rsp0_valid, q_alu_a} !== {2'b10, 8'h5A}) $display("FAIL lat3_exec%0d: got %h exp 25a", i, {q_busy, q_rsp0_valid, q_alu_a}); else pass_cnt++;
      cyc();
    end
    #1;
    tot++; if ({q_rsp0_valid, q_rsp0_y} !== {1'b1, 8'hA5}) $display("FAIL lat3_rsp: got %h exp 1a5", {q_rsp0_valid, q_rsp0_y}); else pass_cnt++;
    cyc();
  endtask
  task automatic test_reset_exec;
    bit bad = 0;
    do_reset();
    req0_valid = 1; req0_a = 8'h01; req0_b = 8'h01; req0_op = 4'b0000; rsp0_ready = 1;
    cyc();
    req0_valid = 0;
    cyc();
    cyc();
    req0_valid = 1;
    cyc();
    req0_valid = 0;
    #1;
    tot++; if (busy !== 1'b1) $display("FAIL rexec_inflight: got %b exp 1", busy); else pass_cnt++;
    rst = 1;
    cyc();
    rst = 0;
    #1;
    tot++; if ({busy, rsp0_valid} !== 2'b00) $display("FAIL rexec_idle: got %b exp 00", {busy, rsp0_valid}); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      if (rsp0_valid || rsp1_valid) bad = 1;
      cyc();
      #1;
    end
    tot++; if (bad !== 1'b0) $display("FAIL rexec_norsp: got %b exp 0", bad); else pass_cnt++;
    req0_valid = 1; req1_valid = 1;
    #1;
    tot++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL rexec_prio: got %b exp 10", {req0_ready, req1_ready}); else pass_cnt++;
    req0_valid = 0; req1_valid = 0;
  endtask
  task automatic test_key;
    logic [7:0] k2, y2;
`ifdef ALU_KEY_LATCH_EN
    k2 = 8'hD3; y2 = 8'h08;
`else
    k2 = 8'hD2; y2 = 8'h02;
`endif
    do_reset();
    req0_valid = 1; req0_a = 8'h05; req0_b = 8'h03; req0_op = 4'b1101; rsp0_ready = 1;
    cyc();
    req0_valid = 0;
    key_we = 1; key_din = 8'hD3;
    #1;
    tot++; if (alu_key !== 8'hD2) $display("FAIL key_exec: got %h exp d2", alu_key); else pass_cnt++;
    cyc();
    key_we = 0;
    #1;
    tot++; if ({rsp0_valid, rsp0_y} !== {1'b1, 8'h02}) $display("FAIL key_first: got %h exp 102", {rsp0_valid, rsp0_y}); else pass_cnt++;
    cyc();
    req0_valid = 1; key_we = 1; key_din = 8'hD2;
    cyc();
    req0_valid = 0; key_we = 0;
    #1;
    tot++; if (alu_key !== k2) $display("FAIL key_second: got %h exp %h", alu_key, k2); else pass_cnt++;
    cyc();
    #1;
    tot++; if ({rsp0_valid, rsp0_y} !== {1'b1, y2}) $display("FAIL key_second_y: got %h exp 1%h", {rsp0_valid, rsp0_y}, y2); else pass_cnt++;
    cyc();
  endtask
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_lat3();
    test_reset_exec();
    test_key();
    $display("%0d/%0d checks passed", pass_cnt, tot);
    $finish;
  end
endmodule
